apb_slave_mem: RTL and testbench

APB completer that terminates one slave-select line from the APB master (Psel_1 or Psel_2) and backs it with a byte-writable word memory. It supports programmable wait states, byte strobes and an error response for out-of-range addresses. Two instances, one per select, form the slave side of the APB subsystem.

---
 rtl/apb_slave_mem.sv | 171 +++++++++++++++++
 tb/tb_apb_slave_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// APB completer for one slave-select line, backed by a byte-writable word
// memory. It has a fixed number of wait states, byte write strobes, and an
// error response for addresses at or beyond DEPTH.
//
// Parameters
//   ADD_WIDTH   : width of Paddr (word address, no byte offset bits; <= 32)
//   WIDTH       : data width, a multiple of 8
//   DEPTH       : number of memory words, <= 2**ADD_WIDTH
//   WAIT_CYCLES : Pready-low cycles inserted in every access phase (0..15)
//
// Ports
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous active-low reset
//   Psel     in   select for this completer
//   Penable  in   access-phase indicator
//   Pwrite   in   1 = write, 0 = read
//   Pstrb    in   byte write strobes (ignored on reads)
//   Paddr    in   word address
//   Pwdata   in   write data
//   Prdata   out  read data, registered, loaded on the read setup edge
//   Pready   out  transfer complete, registered
//   Pslverr  out  error response, registered, valid while Pready=1
// ---------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int unsigned ADD_WIDTH   = 8,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   Psel,
  input  logic                   Penable,
  input  logic                   Pwrite,
  input  logic [WIDTH/8-1:0]     Pstrb,
  input  logic [ADD_WIDTH-1:0]   Paddr,
  input  logic [WIDTH-1:0]       Pwdata,
  output logic [WIDTH-1:0]       Prdata,
  output logic                   Pready,
  output logic                   Pslverr
);

  localparam int unsigned NUM_BYTES = WIDTH / 8;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 err_q,     err_d;
  logic [WIDTH-1:0]     prdata_q,  prdata_d;
  logic                 pready_q,  pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];

  logic                 addr_err_c;
  logic [IDX_W-1:0]     idx_c;
  logic                 wr_commit_c;

  // Address decode; idx_c is only used to touch memory when addr_err_c is low.
  always_comb begin
    addr_err_c = (32'(Paddr) >= 32'(DEPTH));
    idx_c      = Paddr[IDX_W-1:0];
  end

  // Commit on the completing edge of a non-erroring write.
  always_comb begin
    wr_commit_c = (state_q == ACCESS) && Psel && Penable && pready_q &&
                  Pwrite && !err_q;
  end

  // Next-state, wait counter, error capture and read-data load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    prdata_d = prdata_q;

    unique case (state_q)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray Penable is ignored.
        if (Psel && !Penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          err_d   = addr_err_c;
          if (!Pwrite) begin
            prdata_d = addr_err_c ? '0 : mem_q[idx_c];
          end
        end
      end
      ACCESS: begin
        if (!Psel) begin
          // Master abandoned the transfer: abort without committing.
          state_d = IDLE;
        end else if (Penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pready/Pslverr are registered copies of the next-state decode, so they
  // equal (state==ACCESS && cnt==0) without any path from the bus inputs.
  always_comb begin
    pready_d  = (state_d == ACCESS) && (cnt_d == '0);
    pslverr_d = pready_d && err_d;
  end

  // Byte-strobed memory update.
  always_comb begin
    mem_d = mem_q;
    if (wr_commit_c) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (Pstrb[b]) begin
          mem_d[idx_c][8*b +: 8] = Pwdata[8*b +: 8];
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Memory array; cleared by reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_mem
// Two completers share one clock and reset: dut0 with no wait states, dut1
// with three. Each one has its own bus signals and its own reference memory.
// The master drives and samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W0    = 0;
  localparam int unsigned W1    = 3;

  logic        clk;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [3:0]  pstrb   [2];
  logic [7:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] last_rd [2];

  int n_tests = 0;
  int n_fail  = 0;

  apb_slave_mem #(.ADD_WIDTH(8), .WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .pclk(clk), .presetn(rst_n), .Psel(psel[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Pstrb(pstrb[0]), .Paddr(paddr[0]), .Pwdata(pwdata[0]),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
  );

  apb_slave_mem #(.ADD_WIDTH(8), .WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .pclk(clk), .presetn(rst_n), .Psel(psel[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Pstrb(pstrb[1]), .Paddr(paddr[1]), .Pwdata(pwdata[1]),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned waits_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic string tg(input string base, input int d);
    return $sformatf("%s[d%0d]", base, d);
  endfunction

  // One complete transfer; leaves Psel/Penable high so a following call is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd);
    int  cyc;
    bit  exp_err;
    exp_err = (int'(addr) >= int'(DEPTH));
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pstrb[d] = strb; pwdata[d] = wd;
    chk(tg("setup_ready", d), 32'(pready[d]), 32'd0);
    @(negedge clk);
    penable[d] = 1'b1;
    cyc = 1;
    if (!wr) last_rd[d] = exp_err ? 32'd0 : ref_mem[d][addr[5:0]];
    chk(tg(wr ? "rdata_hold" : "rdata", d), prdata[d], last_rd[d]);
    while (!pready[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tg("access_cycles", d), 32'(cyc), 32'(waits_of(d) + 1));
    chk(tg("slverr", d), 32'(pslverr[d]), 32'(exp_err));
    if (wr && !exp_err && pready[d]) begin
      ref_mem[d][addr[5:0]] = merge(ref_mem[d][addr[5:0]], wd, strb);
    end
  endtask

  task automatic bus_idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[d][i] = 32'd0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      pstrb[d] = 4'h0; paddr[d] = 8'h00; pwdata[d] = 32'h0;
    end
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(tg("rst_ready", d), 32'(pready[d]), 32'd0);
      chk(tg("rst_slverr", d), 32'(pslverr[d]), 32'd0);
      chk(tg("rst_rdata", d), prdata[d], 32'd0);
    end
    rst_n = 1'b1;

    // No wait states: reset contents, full write/read, byte strobes.
    xfer(0, 1'b0, 8'h05, 4'h0, 32'h0);
    xfer(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
    xfer(0, 1'b0, 8'h10, 4'h0, 32'h0);
    chk("full_rw_const", prdata[0], 32'hDEADBEEF);
    xfer(0, 1'b1, 8'h20, 4'hF, 32'hFFFFFFFF);
    xfer(0, 1'b1, 8'h20, 4'b0101, 32'h11223344);
    xfer(0, 1'b0, 8'h20, 4'h0, 32'h0);
    chk("strobe_const", prdata[0], 32'hFF22FF44);

    // Out-of-range: erroring write must not alias onto word 0.
    xfer(0, 1'b1, 8'h40, 4'hF, 32'hAAAAAAAA);
    xfer(0, 1'b0, 8'h40, 4'h0, 32'h0);
    chk("err_rdata_const", prdata[0], 32'd0);
    xfer(0, 1'b0, 8'h00, 4'h0, 32'h0);
    bus_idle(0);

    // Penable without a setup phase is ignored.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 8'h10; pwrite[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_enable_ready", 32'(pready[0]), 32'd0);
    end
    bus_idle(0);

    // Wait states: back-to-back write then read at the top word.
    xfer(1, 1'b1, 8'h3F, 4'hF, 32'h12345678);
    xfer(1, 1'b0, 8'h3F, 4'h0, 32'h0);
    chk("w3_b2b_const", prdata[1], 32'h12345678);

    // Abort: Psel dropped during a wait cycle discards the write.
    xfer(1, 1'b1, 8'h01, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h01; pstrb[1] = 4'hF; pwdata[1] = 32'h0BADBEEF;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    chk("abort_wait_ready", 32'(pready[1]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    xfer(1, 1'b0, 8'h01, 4'h0, 32'h0);
    chk("abort_const", prdata[1], 32'hCAFEF00D);
    bus_idle(1);

    // Randomized traffic on both completers, occasionally idling between transfers.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        xfer(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 71)),
             4'($urandom), $urandom);
        if ($urandom_range(0, 3) == 0) bus_idle(d);
      end
      bus_idle(d);
    end

    // Preload, then reset while dut0 shows Pready in its access cycle.
    xfer(0, 1'b1, 8'h02, 4'hF, 32'h55AA55AA);
    xfer(0, 1'b0, 8'h02, 4'h0, 32'h0);
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h02; pstrb[0] = 4'hF; pwdata[0] = 32'h77777777;
    @(negedge clk);
    penable[0] = 1'b1;
    chk("pre_reset_ready", 32'(pready[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_ready", 32'(pready[0]), 32'd0);
    chk("mid_reset_rdata", prdata[0], 32'd0);
    clear_model();
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 8'h02, 4'h0, 32'h0);
    xfer(1, 1'b0, 8'h3F, 4'h0, 32'h0);
    bus_idle(0);
    bus_idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
